// File: rtl/scan_bist_pkg.sv
// Shared types and constants for the logic-BIST controller: FSM states, PRPG/MISR polynomials
// and the PRPG step function.
package scan_bist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCapture,
        StDone
    } bist_state_e;

    // Feedback taps at bits 31, 21, 1 and 0.
    localparam logic [31:0] PRPG_TAPS  = 32'h8020_0003;
    localparam logic [31:0] PRPG_RESET = 32'h0000_0001;
    localparam logic [15:0] MISR_POLY  = 16'h1021;

    function automatic logic [31:0] prpg_next(input logic [31:0] cur);
        return {cur[30:0], ^(cur & PRPG_TAPS)};
    endfunction

endpackage

// File: rtl/scan_bist_ctrl_misr16.sv
// 16-bit multiple-input signature register compacting the scan-out bits of all chains.
module misr16
    import scan_bist_pkg::*;
#(
    parameter int unsigned NUM_CHAINS = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic [NUM_CHAINS-1:0] data_i,
    output logic [15:0]           sig_o
);

    logic [15:0] sig_q, sig_d;
    logic [15:0] data_ext;

    assign data_ext = 16'(data_i);

    always_comb begin
        sig_d = sig_q;
        if (clear_i) begin
            sig_d = '0;
        end else if (enable_i) begin
            sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? MISR_POLY : 16'h0000) ^ data_ext;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/scan_bist_ctrl.sv
// Logic-BIST controller: PRPG-driven scan loads, capture sequencing and MISR unload compaction.
// Optional golden-signature compare (pass/fail outputs) is built when BIST_COMPARE_EN is defined.
module scan_bist_ctrl
    import scan_bist_pkg::*;
#(
    parameter int unsigned NUM_CHAINS = 7,
    parameter int unsigned CHAIN_LEN  = 33,
    parameter int unsigned CNT_W      = 6,
    parameter int unsigned PAT_W      = 16
) (
    input  logic                  CK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [PAT_W-1:0]      pat_count,
    input  logic [31:0]           seed,
`ifdef BIST_COMPARE_EN
    input  logic [15:0]           golden_sig,
    output logic                  pass,
    output logic                  fail,
`endif
    output logic [NUM_CHAINS-1:0] SI,
    input  logic [NUM_CHAINS-1:0] SO,
    output logic                  scan_en,
    output logic                  test_en,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           signature
);

    localparam logic [CNT_W-1:0] LastShift = CNT_W'(CHAIN_LEN - 1);

    bist_state_e       state_q, state_d;
    logic [CNT_W-1:0]  shift_cnt_q, shift_cnt_d;
    logic [PAT_W-1:0]  pat_left_q, pat_left_d;
    logic [31:0]       prpg_q, prpg_d;
    logic              first_q, first_d;
    logic [15:0]       sig_q, sig_d;

    logic              misr_clear;
    logic              misr_en;
    logic [15:0]       misr_sig;
    logic              final_unload;

    // With no captures left the current shift only unloads the last response.
    assign final_unload = (pat_left_q == '0);

    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        pat_left_d  = pat_left_q;
        prpg_d      = prpg_q;
        first_d     = first_q;
        sig_d       = sig_q;
        misr_clear  = 1'b0;
        misr_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    prpg_d      = (seed == 32'h0) ? PRPG_RESET : seed;
                    pat_left_d  = pat_count;
                    shift_cnt_d = '0;
                    first_d     = 1'b1;
                    sig_d       = '0;
                    misr_clear  = 1'b1;
                    state_d     = (pat_count == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                // The first load unloads reset-derived flop contents, so it is not compacted.
                misr_en = ~first_q;
                if (!final_unload) begin
                    prpg_d = prpg_next(prpg_q);
                end
                if (shift_cnt_q == LastShift) begin
                    shift_cnt_d = '0;
                    state_d     = final_unload ? StDone : StCapture;
                end else begin
                    shift_cnt_d = shift_cnt_q + CNT_W'(1);
                end
            end
            StCapture: begin
                pat_left_d  = pat_left_q - PAT_W'(1);
                shift_cnt_d = '0;
                first_d     = 1'b0;
                state_d     = StShift;
            end
            StDone: begin
                sig_d   = misr_sig;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            shift_cnt_q <= '0;
            pat_left_q  <= '0;
            prpg_q      <= PRPG_RESET;
            first_q     <= 1'b0;
            sig_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            pat_left_q  <= pat_left_d;
            prpg_q      <= prpg_d;
            first_q     <= first_d;
            sig_q       <= sig_d;
        end
    end

    misr16 #(
        .NUM_CHAINS(NUM_CHAINS)
    ) u_misr (
        .clk_i   (CK),
        .rst_i   (RST),
        .clear_i (misr_clear),
        .enable_i(misr_en),
        .data_i  (SO),
        .sig_o   (misr_sig)
    );

    always_comb begin
        SI      = '0;
        scan_en = (state_q == StShift);
        test_en = (state_q != StIdle);
        busy    = (state_q == StShift) || (state_q == StCapture);
        done    = (state_q == StDone);
        if ((state_q == StShift) && !final_unload) begin
            SI = prpg_q[NUM_CHAINS-1:0];
        end
        // The final MISR value is presented during the done pulse, then held in sig_q.
        signature = done ? misr_sig : sig_q;
    end

`ifdef BIST_COMPARE_EN
    logic [15:0] golden_q, golden_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic        sig_match;

    assign sig_match = (misr_sig == golden_q);

    always_comb begin
        golden_d = golden_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        if ((state_q == StIdle) && start) begin
            golden_d = golden_sig;
            pass_d   = 1'b0;
            fail_d   = 1'b0;
        end else if (state_q == StDone) begin
            pass_d = sig_match;
            fail_d = ~sig_match;
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            golden_q <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            golden_q <= golden_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
        end
    end

    assign pass = done ? sig_match : pass_q;
    assign fail = done ? ~sig_match : fail_q;
`endif

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// Bench for scan_bist_ctrl: scan chains modelled as a shift-only loopback, signatures predicted
// from pattern-level arithmetic on the PRPG sequence.
module tb_scan_bist_ctrl;

    localparam int NC = 7;
    localparam int CL = 33;

    logic          CK = 1'b0;
    logic          RST = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   pat_count = '0;
    logic [31:0]   seed = '0;
    logic [NC-1:0] SI;
    logic [NC-1:0] SO;
    logic          scan_en, test_en, busy, done;
    logic [15:0]   signature;
`ifdef BIST_COMPARE_EN
    logic [15:0]   golden_sig = '0;
    logic          pass, fail;
`endif

    int errors = 0;
    int checks = 0;

    // Run results captured by the run task
    logic [15:0]   r_sig;
    logic [NC-1:0] r_si0;
    int            r_done_at, r_en_hi, r_first_low;
    logic          r_busy_done;
    logic          r_pass, r_fail;

    scan_bist_ctrl dut (
        .CK        (CK),
        .RST       (RST),
        .start     (start),
        .pat_count (pat_count),
        .seed      (seed),
`ifdef BIST_COMPARE_EN
        .golden_sig(golden_sig),
        .pass      (pass),
        .fail      (fail),
`endif
        .SI        (SI),
        .SO        (SO),
        .scan_en   (scan_en),
        .test_en   (test_en),
        .busy      (busy),
        .done      (done),
        .signature (signature)
    );

    always #5 CK = ~CK;

    // Scan chains: each shifts only while scan_en, capture leaves contents untouched.
    logic [NC-1:0] chain_q [CL];
    always @(posedge CK) begin
        if (scan_en) begin
            for (int k = CL - 1; k > 0; k--) chain_q[k] <= chain_q[k-1];
            chain_q[0] <= SI;
        end
    end
    assign SO = chain_q[CL-1];

    function automatic logic [31:0] adv(input logic [31:0] r);
        return {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
    endfunction

    function automatic logic [31:0] eff_seed(input logic [31:0] sd);
        return (sd == 32'h0) ? 32'h1 : sd;
    endfunction

    // Pattern i's unload observes pattern i-1's load at the same shift position.
    function automatic logic [15:0] model_sig(input int p, input logic [31:0] sd);
        logic [31:0]   r;
        logic [15:0]   m;
        logic [NC-1:0] pat [CL];
        r = eff_seed(sd);
        m = 16'h0;
        if (p == 0) return 16'h0;
        for (int c = 0; c < CL; c++) begin
            pat[c] = r[NC-1:0];
            r = adv(r);
        end
        for (int i = 1; i <= p; i++) begin
            for (int c = 0; c < CL; c++) begin
                m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0) ^ 16'(pat[c]);
                if (i < p) begin
                    pat[c] = r[NC-1:0];
                    r = adv(r);
                end
            end
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // n counts edges after the accepting edge; poke_at>=0 pulses start mid-run.
    task automatic run(input int p, input logic [31:0] sd, input int poke_at);
        pat_count = 16'(p);
        seed      = sd;
        start     = 1'b1;
        tick();
        start       = 1'b0;
        r_done_at   = -1;
        r_en_hi     = 0;
        r_first_low = -1;
        r_si0       = SI;
        for (int n = 0; n < 2000 && r_done_at < 0; n++) begin
            if (n > 0) tick();
            if (n == poke_at) begin
                start     = 1'b1;
                pat_count = 16'(p + 3);
                seed      = ~sd;
            end else if (n == poke_at + 1) begin
                start = 1'b0;
            end
            if (scan_en) r_en_hi++;
            else if (r_first_low < 0 && !done) r_first_low = n;
            if (done) begin
                r_done_at   = n;
                r_sig       = signature;
                r_busy_done = busy;
`ifdef BIST_COMPARE_EN
                r_pass = pass;
                r_fail = fail;
`else
                r_pass = 1'b0;
                r_fail = 1'b0;
`endif
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int          p;
        logic [31:0] sd;
        logic [15:0] exp_sig;

        // Asynchronous reset with no clock edge in between
        #3 RST = 1'b1;
        #1;
        check("rst_si", 32'(SI), 0);
        check("rst_scan_en", 32'(scan_en), 0);
        check("rst_test_en", 32'(test_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_signature", 32'(signature), 0);
        repeat (2) @(negedge CK);
        RST = 1'b0;
        tick();

        // Single pattern timing
        run(1, 32'h1, -1);
        check("p1_si0", 32'(r_si0), 32'h1);
        check("p1_done_at", r_done_at, 67);
        check("p1_scan_en_cycles", r_en_hi, 66);
        check("p1_capture_at", r_first_low, 33);
        check("p1_busy_at_done", 32'(r_busy_done), 0);
        check("p1_sig", 32'(r_sig), 32'(model_sig(1, 32'h1)));
        tick();
        check("p1_done_pulse", 32'(done), 0);
        check("p1_idle_test_en", 32'(test_en), 0);
        repeat (3) tick();
        check("p1_sig_held", 32'(signature), 32'(model_sig(1, 32'h1)));

        // Zero patterns
        run(0, 32'h1234, -1);
        check("p0_done_at", r_done_at, 0);
        check("p0_scan_en_cycles", r_en_hi, 0);
        check("p0_sig", 32'(r_sig), 0);
        tick();

        // Reference run, repeated
        exp_sig = model_sig(4, 32'hACE1);
        for (int k = 0; k < 2; k++) begin
            run(4, 32'hACE1, -1);
            check("ace1_si0", 32'(r_si0), 32'(7'h61));
            check("ace1_done_at", r_done_at, 4 * (CL + 1) + CL);
            check("ace1_sig", 32'(r_sig), 32'(exp_sig));
            tick();
        end

        // Start pulsed while busy must not disturb the run
        sd = $urandom;
        run(3, sd, 20);
        check("busy_start_done_at", r_done_at, 3 * (CL + 1) + CL);
        check("busy_start_sig", 32'(r_sig), 32'(model_sig(3, sd)));
        tick();

        // Zero seed behaves as seed 1
        run(2, 32'h0, -1);
        check("seed0_si0", 32'(r_si0), 32'h1);
        check("seed0_sig", 32'(r_sig), 32'(model_sig(2, 32'h0)));
        tick();

        // Randomized runs
        for (int k = 0; k < 4; k++) begin
            p  = $urandom_range(1, 6);
            sd = $urandom;
            run(p, sd, -1);
            check("rand_si0", 32'(r_si0), 32'(eff_seed(sd) & 32'h7f));
            check("rand_done_at", r_done_at, p * (CL + 1) + CL);
            check("rand_sig", 32'(r_sig), 32'(model_sig(p, sd)));
            repeat (1 + k) tick();
        end

        // Reset during shift cycle 10 of pattern 2
        pat_count = 16'd4;
        seed      = 32'hACE1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (CL + 1 + 10) tick();
        check("mid_scan_en_before_rst", 32'(scan_en), 1);
        #3 RST = 1'b1;
        #1;
        check("mid_rst_scan_en", 32'(scan_en), 0);
        check("mid_rst_test_en", 32'(test_en), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_si", 32'(SI), 0);
        check("mid_rst_signature", 32'(signature), 0);
        repeat (2) @(negedge CK);
        RST = 1'b0;
        tick();
        run(4, 32'hACE1, -1);
        check("mid_rerun_sig", 32'(r_sig), 32'(exp_sig));
        tick();

`ifdef BIST_COMPARE_EN
        golden_sig = model_sig(2, 32'h5a5a_1234);
        run(2, 32'h5a5a_1234, -1);
        check("cmp_pass", 32'(r_pass), 1);
        check("cmp_fail", 32'(r_fail), 0);
        tick();
        check("cmp_pass_held", 32'(pass), 1);
        golden_sig = model_sig(2, 32'h5a5a_1234) ^ 16'h0001;
        run(2, 32'h5a5a_1234, -1);
        check("cmp_bad_pass", 32'(r_pass), 0);
        check("cmp_bad_fail", 32'(r_fail), 1);
        tick();
        check("cmp_bad_fail_held", 32'(fail), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
